// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word per valid/ready
// handshake and shifts it out one bit per clock with frame and last-bit strobes.
module shift_reg_piso_tx #(
  parameter int unsigned WIDTH     = 10,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_last
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_frame_q, ser_frame_d;
  logic             ser_last_q, ser_last_d;
  logic             accept;

  // Ready depends only on registered state so in_valid never loops back into it.
  assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && ser_last_q);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_frame_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_frame_q <= ser_frame_d;
      ser_last_q  <= ser_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ser_out_d   = 1'b0;
    ser_frame_d = 1'b0;
    ser_last_d  = 1'b0;

    if (accept) begin
      // First bit is presented straight from the incoming word.
      state_d     = SHIFT;
      shreg_d     = in_data;
      cnt_d       = '0;
      ser_out_d   = LSB_FIRST ? in_data[0] : in_data[WIDTH-1];
      ser_frame_d = 1'b1;
    end else if ((state_q == SHIFT) && !ser_last_q) begin
      cnt_d       = cnt_q + CW'(1);
      shreg_d     = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
      ser_out_d   = LSB_FIRST ? shreg_q[1] : shreg_q[WIDTH-2];
      ser_frame_d = 1'b1;
      ser_last_d  = (cnt_d == CW'(WIDTH - 1));
    end else if (state_q == SHIFT) begin
      state_d = IDLE;
      cnt_d   = '0;
      shreg_d = '0;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_frame = ser_frame_q;
  assign ser_last  = ser_last_q;

endmodule
